// File: rtl/mem_stage_if.sv
// Data-bus bundle between the memory stage (master) and the data memory (slave).
interface mem_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: forwards ALU results to writeback after one register, and runs
// loads/stores over a req/gnt/rvalid data bus with byte-lane steering and sign extension.
module mem_stage #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_valid_i,
  input  logic               rd_we_i,
  input  logic [DATA_W-1:0]  rd_data_i,
  input  logic [RADDR_W-1:0] rd_addr_i,
  input  logic [3:0]         mem_op_i,
  input  logic [DATA_W-1:0]  st_data_i,
  output logic               stall_o,
  output logic               misalign_o,
  mem_stage_if.master        dbus,
  output logic               wb_we_o,
  output logic [RADDR_W-1:0] wb_addr_o,
  output logic [DATA_W-1:0]  wb_data_o
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t state_q, state_d;

  logic        is_load, is_store, is_mem, mis, accept;
  logic [1:0]  sz;

  logic [31:0]        addr_p1;
  logic [3:0]         be_p1;
  logic [31:0]        wdata_p1;
  logic               we_p1;
  logic [1:0]         lane_p1;
  logic [3:0]         op_p1;
  logic [RADDR_W-1:0] rd_p1;

  function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: lane_enables = 4'b0001 << lane;
      SZ_HALF: lane_enables = 4'b0011 << lane;
      default: lane_enables = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SZ_BYTE: replicate = {4{data[7:0]}};
      SZ_HALF: replicate = {2{data[15:0]}};
      default: replicate = data;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [3:0] op, input logic [1:0] lane,
                                              input logic [31:0] rdata);
    logic [31:0] shifted;
    shifted = rdata >> {lane, 3'b000};
    case (op)
      OP_LB:   load_extend = {{24{shifted[7]}}, shifted[7:0]};
      OP_LBU:  load_extend = {24'd0, shifted[7:0]};
      OP_LH:   load_extend = {{16{shifted[15]}}, shifted[15:0]};
      OP_LHU:  load_extend = {16'd0, shifted[15:0]};
      default: load_extend = shifted;
    endcase
  endfunction

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sz       = SZ_WORD;
    case (mem_op_i)
      OP_LB, OP_LBU: begin is_load  = 1'b1; sz = SZ_BYTE; end
      OP_LH, OP_LHU: begin is_load  = 1'b1; sz = SZ_HALF; end
      OP_LW:         begin is_load  = 1'b1; sz = SZ_WORD; end
      OP_SB:         begin is_store = 1'b1; sz = SZ_BYTE; end
      OP_SH:         begin is_store = 1'b1; sz = SZ_HALF; end
      OP_SW:         begin is_store = 1'b1; sz = SZ_WORD; end
      default: ;
    endcase
    is_mem = is_load | is_store;
    mis    = ((sz == SZ_HALF) && rd_data_i[0]) || ((sz == SZ_WORD) && (rd_data_i[1:0] != 2'b00));
    accept = ex_valid_i && is_mem && !mis;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // stall drops on the rvalid cycle so upstream advances exactly as the response lands
  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall_o = accept;
        if (accept) state_d = S_REQ;
      end
      S_REQ: begin
        stall_o = 1'b1;
        if (dbus.gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        stall_o = !dbus.rvalid;
        if (dbus.rvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // p1: access latched at acceptance, writeback/misalign registered one cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_p1    <= '0;
      be_p1      <= '0;
      wdata_p1   <= '0;
      we_p1      <= 1'b0;
      lane_p1    <= '0;
      op_p1      <= '0;
      rd_p1      <= '0;
      misalign_o <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_addr_o  <= '0;
      wb_data_o  <= '0;
    end else begin
      misalign_o <= 1'b0;
      wb_we_o    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            addr_p1  <= {rd_data_i[31:2], 2'b00};
            be_p1    <= lane_enables(sz, rd_data_i[1:0]);
            wdata_p1 <= replicate(sz, st_data_i);
            we_p1    <= is_store;
            lane_p1  <= rd_data_i[1:0];
            op_p1    <= mem_op_i;
            rd_p1    <= rd_addr_i;
          end else if (ex_valid_i && is_mem) begin
            misalign_o <= 1'b1;
          end else if (ex_valid_i) begin
            wb_we_o   <= rd_we_i && (rd_addr_i != '0);
            wb_addr_o <= rd_addr_i;
            wb_data_o <= rd_data_i;
          end
        end
        S_WAIT: begin
          if (dbus.rvalid && !we_p1) begin
            wb_we_o   <= (rd_p1 != '0);
            wb_addr_o <= rd_p1;
            wb_data_o <= load_extend(op_p1, lane_p1, dbus.rdata);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    dbus.req   = (state_q == S_REQ);
    dbus.we    = dbus.req ? we_p1    : 1'b0;
    dbus.addr  = dbus.req ? addr_p1  : '0;
    dbus.be    = dbus.req ? be_p1    : '0;
    dbus.wdata = dbus.req ? wdata_p1 : '0;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: vector table for single-cycle cases, hand sequences for bus corners,
// and randomized traffic against an arithmetic reference model.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid_i = 1'b0;
  logic        rd_we_i = 1'b0;
  logic [31:0] rd_data_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic [3:0]  mem_op_i = '0;
  logic [31:0] st_data_i = '0;
  logic        stall_o, misalign_o, wb_we_o;
  logic [4:0]  wb_addr_o;
  logic [31:0] wb_data_o;

  int checks = 0;
  int failures = 0;

  mem_stage_if dbus();

  mem_stage #(.DATA_W(32), .RADDR_W(5)) dut (
    .clk(clk), .rst(rst), .ex_valid_i(ex_valid_i), .rd_we_i(rd_we_i), .rd_data_i(rd_data_i),
    .rd_addr_i(rd_addr_i), .mem_op_i(mem_op_i), .st_data_i(st_data_i), .stall_o(stall_o),
    .misalign_o(misalign_o), .dbus(dbus), .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o),
    .wb_data_o(wb_data_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [3:0]  op;
    logic        rdwe;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exp_we;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int op_bytes(input int op);
    if (op == 1 || op == 4 || op == 6) return 1;
    if (op == 2 || op == 5 || op == 7) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] ref_be(input int op, input logic [31:0] addr);
    int n = op_bytes(op);
    int m = ((1 << n) - 1) << (addr % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input int op, input logic [31:0] st);
    int n = op_bytes(op);
    if (n == 1) return (st & 32'hFF) * 32'h0101_0101;
    if (n == 2) return (st & 32'hFFFF) * 32'h0001_0001;
    return st;
  endfunction

  function automatic logic [31:0] ref_load(input int op, input logic [31:0] addr, input logic [31:0] rdata);
    int n = op_bytes(op);
    longint v = longint'(rdata >> (8 * (addr % 4))) % (64'sd1 << (8 * n));
    if ((op == 1 || op == 2) && v >= (64'sd1 << (8 * n - 1))) v = v - (64'sd1 << (8 * n));
    return v[31:0];
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_stall"}, {31'd0, stall_o}, 32'd0);
    chk({tag, "_req"},   {31'd0, dbus.req}, 32'd0);
  endtask

  task automatic apply_single(input string tag, input logic valid, input logic [3:0] op, input logic rdwe,
                              input logic [4:0] rd, input logic [31:0] data,
                              input logic exp_we, input logic exp_mis);
    ex_valid_i = valid; mem_op_i = op; rd_we_i = rdwe; rd_addr_i = rd; rd_data_i = data;
    st_data_i = $urandom;
    #1;
    check_idle_outputs(tag);
    @(posedge clk); #1;
    ex_valid_i = 1'b0; mem_op_i = 4'd0;
    chk({tag, "_wb_we"},    {31'd0, wb_we_o},    {31'd0, exp_we});
    chk({tag, "_misalign"}, {31'd0, misalign_o}, {31'd0, exp_mis});
    chk({tag, "_req_after"}, {31'd0, dbus.req}, 32'd0);
    if (exp_we) begin
      chk({tag, "_wb_addr"}, {27'd0, wb_addr_o}, {27'd0, rd});
      chk({tag, "_wb_data"}, wb_data_o, data);
    end
    @(posedge clk); #1;
    chk({tag, "_pulse_end"}, {30'd0, wb_we_o, misalign_o}, 32'd0);
  endtask

  task automatic check_req(input string tag, input int op, input logic [31:0] addr, input logic [31:0] st);
    chk({tag, "_req"},   {31'd0, dbus.req}, 32'd1);
    chk({tag, "_stall"}, {31'd0, stall_o},  32'd1);
    chk({tag, "_we"},    {31'd0, dbus.we},  {31'd0, (op >= 6)});
    chk({tag, "_addr"},  dbus.addr, addr & 32'hFFFF_FFFC);
    chk({tag, "_be"},    {28'd0, dbus.be}, {28'd0, ref_be(op, addr)});
    if (op >= 6) chk({tag, "_wdata"}, dbus.wdata, ref_wdata(op, st));
  endtask

  // gdly: cycles of REQ before gnt; rvdly: cycles from gnt to rvalid (>=1)
  task automatic do_mem(input string tag, input int op, input logic [31:0] addr, input logic [31:0] st,
                        input logic [4:0] rd, input logic [31:0] rdata, input int gdly, input int rvdly);
    logic exp_we;
    exp_we = (op <= 5) && (rd != 5'd0);
    ex_valid_i = 1'b1; mem_op_i = 4'(op); rd_data_i = addr; st_data_i = st; rd_addr_i = rd; rd_we_i = 1'b1;
    #1;
    chk({tag, "_accept_stall"}, {31'd0, stall_o}, 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < gdly; i++) begin
      check_req(tag, op, addr, st);
      @(posedge clk); #1;
    end
    dbus.gnt = 1'b1;
    #1;
    check_req(tag, op, addr, st);
    @(posedge clk); #1;
    dbus.gnt = 1'b0;
    chk({tag, "_wait_req"},   {31'd0, dbus.req}, 32'd0);
    chk({tag, "_wait_stall"}, {31'd0, stall_o},  32'd1);
    for (int i = 1; i < rvdly; i++) begin
      @(posedge clk); #1;
      chk({tag, "_wait_stall"}, {31'd0, stall_o}, 32'd1);
    end
    dbus.rvalid = 1'b1; dbus.rdata = rdata;
    #1;
    chk({tag, "_rvalid_stall"}, {31'd0, stall_o}, 32'd0);
    @(posedge clk); #1;
    dbus.rvalid = 1'b0; ex_valid_i = 1'b0; mem_op_i = 4'd0;
    chk({tag, "_wb_we"}, {31'd0, wb_we_o}, {31'd0, exp_we});
    if (exp_we) begin
      chk({tag, "_wb_addr"}, {27'd0, wb_addr_o}, {27'd0, rd});
      chk({tag, "_wb_data"}, wb_data_o, ref_load(op, addr, rdata));
    end
    @(posedge clk); #1;
    chk({tag, "_wb_pulse_end"}, {31'd0, wb_we_o}, 32'd0);
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] raddr;
    logic        rwe;
    logic [4:0]  rrd;
    int          op, n;

    dbus.gnt = 1'b0; dbus.rvalid = 1'b0; dbus.rdata = '0;

    vecs[0]  = '{1'b1, 4'd0,  1'b1, 5'd5,  32'h1234_5678, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 4'd0,  1'b1, 5'd0,  32'h0000_DEAD, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 4'd0,  1'b0, 5'd7,  32'h0000_0001, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 4'd0,  1'b1, 5'd9,  32'h0000_0055, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 4'd9,  1'b1, 5'd12, 32'hCAFE_F00D, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 4'd15, 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 4'd3,  1'b1, 5'd4,  32'h0000_0101, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 4'd7,  1'b1, 5'd4,  32'h0000_0203, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 4'd2,  1'b1, 5'd8,  32'h0000_0001, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 4'd8,  1'b1, 5'd8,  32'h0000_0102, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 4'd5,  1'b1, 5'd8,  32'h0000_0003, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_stall", {31'd0, stall_o}, 32'd0);
    chk("reset_bus", {dbus.req, dbus.we, dbus.be, 26'd0} | dbus.addr | dbus.wdata, 32'd0);
    chk("reset_wb", {wb_we_o, misalign_o, 25'd0, wb_addr_o} | wb_data_o, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++)
      apply_single($sformatf("vec%0d", i), vecs[i].valid, vecs[i].op, vecs[i].rdwe, vecs[i].rd,
                   vecs[i].data, vecs[i].exp_we, vecs[i].exp_mis);

    do_mem("lb_late", 1, 32'h0000_0103, 32'd0, 5'd9, 32'h80FF_0000, 2, 3);
    do_mem("sh_lane", 7, 32'h0000_0202, 32'h0000_ABCD, 5'd2, 32'd0, 0, 1);
    do_mem("lhu_x0", 5, 32'h0000_0000, 32'd0, 5'd0, 32'h0000_8001, 1, 2);
    do_mem("lh_rd3", 2, 32'h0000_0000, 32'd0, 5'd3, 32'h0000_8001, 0, 1);

    // reset while waiting for the response
    ex_valid_i = 1'b1; mem_op_i = 4'd3; rd_data_i = 32'h0000_0100; rd_addr_i = 5'd6; rd_we_i = 1'b1;
    @(posedge clk); #1;
    dbus.gnt = 1'b1;
    @(posedge clk); #1;
    dbus.gnt = 1'b0;
    chk("rst_mid_wait_stall", {31'd0, stall_o}, 32'd1);
    #2;
    ex_valid_i = 1'b0; mem_op_i = 4'd0; rst = 1'b1;
    #1;
    chk("rst_mid_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_mid_bus", {dbus.req, dbus.we, dbus.be, 26'd0} | dbus.addr | dbus.wdata, 32'd0);
    chk("rst_mid_wb", {wb_we_o, misalign_o, 25'd0, wb_addr_o} | wb_data_o, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    dbus.rvalid = 1'b1; dbus.rdata = 32'h1111_2222;
    #1;
    chk("late_rvalid_stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk); #1;
    dbus.rvalid = 1'b0;
    chk("late_rvalid_wb", {31'd0, wb_we_o}, 32'd0);
    @(posedge clk); #1;
    chk("late_rvalid_wb2", {31'd0, wb_we_o}, 32'd0);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        rop = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(9, 15));
        rwe = 1'($urandom_range(0, 1));
        rrd = 5'($urandom_range(0, 31));
        raddr = $urandom;
        apply_single($sformatf("rnd%0d_none", it), 1'b1, rop, rwe, rrd, raddr,
                     rwe && (rrd != 5'd0), 1'b0);
      end else begin
        op = $urandom_range(1, 8);
        n = op_bytes(op);
        raddr = $urandom & ~(32'(n - 1));
        do_mem($sformatf("rnd%0d_op%0d", it, op), op, raddr, $urandom, 5'($urandom_range(0, 31)),
               $urandom, $urandom_range(0, 3), $urandom_range(1, 3));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
